// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined CPU: word/control encodings
// and the memory-stage state enum.
package cpu_types_pkg;

    localparam int MEM_WORD_W = 32;
    localparam int MEM_REG_W  = 5;
    localparam int LINK_LSB   = 2;

    typedef logic [MEM_WORD_W-1:0] word_t;

    // Field order puts dREN in bit 0 so the struct overlays ex_memctrl directly
    typedef struct packed {
        logic [1:0] rsvd;
        logic       halt;
        logic       dWEN;
        logic       dREN;
    } memctrl_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_link_reg.sv
// LL/SC link register: remembers the word reserved by the last LL and
// reports whether an SC in flight may still succeed.
module link_reg #(
    parameter int WORD_W   = 32,
    parameter int LINK_LSB = 2
) (
    input  logic              i_clk,
    input  logic              i_rstN,
    input  logic              i_set,
    input  logic [WORD_W-1:0] i_setAddr,
    input  logic              i_clear,
    input  logic              i_storeKill,
    input  logic [WORD_W-1:0] i_storeAddr,
    input  logic              i_snoop,
    input  logic [WORD_W-1:0] i_snoopAddr,
    input  logic [WORD_W-1:0] i_cmpAddr,
    output logic              o_scPass
);

    localparam int TAG_W = WORD_W - LINK_LSB;

    logic             r_valid;
    logic [TAG_W-1:0] r_tag;

    logic w_snoopHit;
    logic w_storeHit;
    logic w_cmpHit;
    logic w_unused;

    assign w_snoopHit = i_snoop     & (i_snoopAddr[WORD_W-1:LINK_LSB] == r_tag);
    assign w_storeHit = i_storeKill & (i_storeAddr[WORD_W-1:LINK_LSB] == r_tag);
    assign w_cmpHit   = (i_cmpAddr[WORD_W-1:LINK_LSB] == r_tag);

    // A snoop landing in the same cycle as the SC check already kills the reservation
    assign o_scPass = r_valid & w_cmpHit & ~w_snoopHit;

    // Byte offsets inside a word never take part in the reservation
    assign w_unused = ^{i_setAddr[LINK_LSB-1:0], i_storeAddr[LINK_LSB-1:0],
                        i_snoopAddr[LINK_LSB-1:0], i_cmpAddr[LINK_LSB-1:0]};

    // Set beats every clear source because the new LL is younger than any snoop
    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
        end else if (i_set) begin
            r_valid <= 1'b1;
            r_tag   <= i_setAddr[WORD_W-1:LINK_LSB];
        end else if (i_clear | w_snoopHit | w_storeHit) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues data-cache requests, stalls until dhit, tracks the
// LL/SC reservation and registers results into the MEM/WB latch.
module mem_stage #(
    parameter int WORD_W   = cpu_types_pkg::MEM_WORD_W,
    parameter int REG_W    = cpu_types_pkg::MEM_REG_W,
    parameter int LINK_LSB = cpu_types_pkg::LINK_LSB
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_valid,
    input  logic [4:0]        ex_memctrl,
    input  logic [3:0]        ex_wbctrl,
    input  logic              ex_atomic,
    input  logic [WORD_W-1:0] ex_aluout,
    input  logic [WORD_W-1:0] ex_store,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    output logic              stall_mem,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_wdat,
    output logic [3:0]        wb_wbctrl,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_halt
);

    import cpu_types_pkg::*;

    mem_state_t r_state;
    mem_state_t w_nextState;

    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_data;
    logic              r_write;
    logic              r_atomic;
    logic [3:0]        r_wbctrl;
    logic [REG_W-1:0]  r_rd;

    logic              r_wbValid;
    logic [WORD_W-1:0] r_wbWdat;
    logic [3:0]        r_wbWbctrl;
    logic [REG_W-1:0]  r_wbRd;
    logic              r_wbHalt;

    memctrl_t w_ctrl;
    logic     w_write;
    logic     w_read;
    logic     w_isSc;
    logic     w_isLl;
    logic     w_scPass;
    logic     w_issue;
    logic     w_unused;

    assign w_ctrl   = ex_memctrl;
    assign w_write  = w_ctrl.dWEN & ~w_ctrl.halt;
    assign w_read   = w_ctrl.dREN & ~w_ctrl.dWEN & ~w_ctrl.halt;
    assign w_isSc   = w_write & ex_atomic;
    assign w_isLl   = w_read & ex_atomic;
    assign w_issue  = ex_valid & (w_write | w_read) & (~w_isSc | w_scPass);
    assign w_unused = ^{w_ctrl.rsvd, w_isLl};

    assign wb_valid  = r_wbValid;
    assign wb_wdat   = r_wbWdat;
    assign wb_wbctrl = r_wbWbctrl;
    assign wb_rd     = r_wbRd;
    assign wb_halt   = r_wbHalt;

    link_reg #(
        .WORD_W   (WORD_W),
        .LINK_LSB (LINK_LSB)
    ) u_linkReg (
        .i_clk       (CLK),
        .i_rstN      (nRST),
        .i_set       ((r_state == ACCESS) & dhit & ~r_write & r_atomic),
        .i_setAddr   (r_addr),
        .i_clear     ((r_state == IDLE) & ex_valid & w_isSc),
        .i_storeKill ((r_state == ACCESS) & dhit & r_write & ~r_atomic),
        .i_storeAddr (r_addr),
        .i_snoop     (snoop_inv),
        .i_snoopAddr (snoop_addr),
        .i_cmpAddr   (ex_aluout),
        .o_scPass    (w_scPass)
    );

    // Next-state and cache request outputs; requests only come from the captured copy
    always_comb begin
        w_nextState = r_state;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        daddr       = '0;
        dstore      = '0;
        stall_mem   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    stall_mem   = 1'b1;
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                dREN      = ~r_write;
                dWEN      = r_write;
                daddr     = r_addr;
                dstore    = r_data;
                stall_mem = ~dhit;
                if (dhit) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register, request capture and MEM/WB latch; stalled edges push a bubble
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_data     <= '0;
            r_write    <= 1'b0;
            r_atomic   <= 1'b0;
            r_wbctrl   <= '0;
            r_rd       <= '0;
            r_wbValid  <= 1'b0;
            r_wbWdat   <= '0;
            r_wbWbctrl <= '0;
            r_wbRd     <= '0;
            r_wbHalt   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_addr    <= ex_aluout;
                        r_data    <= ex_store;
                        r_write   <= w_write;
                        r_atomic  <= ex_atomic;
                        r_wbctrl  <= ex_wbctrl;
                        r_rd      <= ex_rd;
                        r_wbValid <= 1'b0;
                        r_wbHalt  <= 1'b0;
                    end else if (ex_valid) begin
                        r_wbValid  <= 1'b1;
                        r_wbWdat   <= w_isSc ? '0 : ex_aluout;
                        r_wbWbctrl <= ex_wbctrl;
                        r_wbRd     <= ex_rd;
                        r_wbHalt   <= w_ctrl.halt;
                    end else begin
                        r_wbValid <= 1'b0;
                        r_wbHalt  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        r_wbValid  <= 1'b1;
                        r_wbWdat   <= !r_write ? dload : (r_atomic ? WORD_W'(1) : r_addr);
                        r_wbWbctrl <= r_wbctrl;
                        r_wbRd     <= r_rd;
                        r_wbHalt   <= 1'b0;
                    end else begin
                        r_wbValid <= 1'b0;
                        r_wbHalt  <= 1'b0;
                    end
                end
                default: r_wbValid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instruction streams checked against a transaction-level reference model.
module tb_mem_stage;

    localparam int K_ALU  = 0;
    localparam int K_LW   = 1;
    localparam int K_SW   = 2;
    localparam int K_LL   = 3;
    localparam int K_SC   = 4;
    localparam int K_HALT = 5;
    localparam int K_RW   = 6;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ex_valid;
    logic [4:0]  ex_memctrl;
    logic [3:0]  ex_wbctrl;
    logic        ex_atomic;
    logic [31:0] ex_aluout;
    logic [31:0] ex_store;
    logic [4:0]  ex_rd;
    logic        dhit;
    logic [31:0] dload;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        stall_mem;
    logic        wb_valid;
    logic [31:0] wb_wdat;
    logic [3:0]  wb_wbctrl;
    logic [4:0]  wb_rd;
    logic        wb_halt;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference reservation: is a word linked, and which one
    bit          modelLinkValid;
    logic [31:0] modelLinkAddr;

    mem_stage dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ex_valid   (ex_valid),
        .ex_memctrl (ex_memctrl),
        .ex_wbctrl  (ex_wbctrl),
        .ex_atomic  (ex_atomic),
        .ex_aluout  (ex_aluout),
        .ex_store   (ex_store),
        .ex_rd      (ex_rd),
        .dhit       (dhit),
        .dload      (dload),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .daddr      (daddr),
        .dstore     (dstore),
        .stall_mem  (stall_mem),
        .wb_valid   (wb_valid),
        .wb_wdat    (wb_wdat),
        .wb_wbctrl  (wb_wbctrl),
        .wb_rd      (wb_rd),
        .wb_halt    (wb_halt)
    );

    // Free-running clock, posedge at 5, 15, 25 ...
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit sameWord(input logic [31:0] a, input logic [31:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

    function automatic logic [31:0] pickAddr();
        case ($urandom_range(0, 5))
            0:       return 32'h100;
            1:       return 32'h104;
            2:       return 32'h200;
            3:       return 32'h202;
            4:       return 32'h400;
            default: return 32'h600;
        endcase
    endfunction

    task automatic modelSnoop(input bit s, input logic [31:0] a);
        if (s && modelLinkValid && sameWord(a, modelLinkAddr))
            modelLinkValid = 1'b0;
    endtask

    // One instruction from EX/MEM until it lands in MEM/WB.
    // accessSnoopMode: 0 none, 1 random snoops, 2 snoop snoopAddr every access cycle
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] loadVal, input logic [4:0] rd,
                                 input logic [3:0] wbctrl, input int hitDelay,
                                 input bit idleSnoop, input logic [31:0] snoopAddr,
                                 input int accessSnoopMode);
        bit isRead, isWrite, isSc, isLl, scPass, issue;
        logic [31:0] expWdat;
        isRead  = (kind == K_LW) || (kind == K_LL);
        isWrite = (kind == K_SW) || (kind == K_SC) || (kind == K_RW);
        isSc    = (kind == K_SC);
        isLl    = (kind == K_LL);
        case (kind)
            K_LW, K_LL: ex_memctrl = 5'b00001;
            K_SW, K_SC: ex_memctrl = 5'b00010;
            K_RW:       ex_memctrl = 5'b00011;
            K_HALT:     ex_memctrl = 5'b00100;
            default:    ex_memctrl = 5'b00000;
        endcase
        ex_valid   = 1'b1;
        ex_atomic  = isSc || isLl;
        ex_aluout  = addr;
        ex_store   = data;
        ex_rd      = rd;
        ex_wbctrl  = wbctrl;
        dhit       = 1'b0;
        dload      = loadVal;
        snoop_inv  = idleSnoop;
        snoop_addr = snoopAddr;
        #1;
        scPass = modelLinkValid && sameWord(addr, modelLinkAddr)
                 && !(idleSnoop && sameWord(snoopAddr, modelLinkAddr));
        issue  = (isRead || isWrite) && (!isSc || scPass);
        checkOutput("stall_idle", 32'(stall_mem), 32'(issue));
        checkOutput("req_idle", {30'd0, dREN, dWEN}, 32'd0);
        if (isSc) modelLinkValid = 1'b0;
        modelSnoop(idleSnoop, snoopAddr);
        tick();
        if (!issue) begin
            expWdat = isSc ? 32'd0 : addr;
        end else begin
            for (int k = 0; k <= hitDelay; k++) begin
                checkOutput("wb_bubble", 32'(wb_valid), 32'd0);
                dhit = (k == hitDelay);
                if (accessSnoopMode == 1) begin
                    snoop_inv  = ($urandom_range(0, 2) == 0);
                    snoop_addr = pickAddr();
                end else begin
                    snoop_inv  = (accessSnoopMode == 2);
                    snoop_addr = snoopAddr;
                end
                #1;
                checkOutput("dREN", 32'(dREN), 32'(isRead));
                checkOutput("dWEN", 32'(dWEN), 32'(isWrite));
                checkOutput("daddr", daddr, addr);
                if (isWrite) checkOutput("dstore", dstore, data);
                checkOutput("stall_access", 32'(stall_mem), 32'(k != hitDelay));
                modelSnoop(snoop_inv, snoop_addr);
                if (k == hitDelay) begin
                    if (isLl) begin
                        modelLinkValid = 1'b1;
                        modelLinkAddr  = addr;
                    end
                    if (isWrite && !isSc && sameWord(addr, modelLinkAddr))
                        modelLinkValid = 1'b0;
                end
                tick();
            end
            dhit      = 1'b0;
            snoop_inv = 1'b0;
            expWdat   = isRead ? loadVal : (isSc ? 32'd1 : addr);
        end
        checkOutput("wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("wb_wdat", wb_wdat, expWdat);
        checkOutput("wb_rd", 32'(wb_rd), 32'(rd));
        checkOutput("wb_wbctrl", 32'(wb_wbctrl), 32'(wbctrl));
        checkOutput("wb_halt", 32'(wb_halt), 32'(kind == K_HALT));
        checkOutput("req_done", {30'd0, dREN, dWEN}, 32'd0);
        snoop_inv = 1'b0;
    endtask

    // A cycle with no live instruction, optionally carrying a snoop
    task automatic idleCycle(input bit s, input logic [31:0] a);
        ex_valid   = 1'b0;
        dhit       = 1'b0;
        snoop_inv  = s;
        snoop_addr = a;
        #1;
        checkOutput("stall_nop", 32'(stall_mem), 32'd0);
        modelSnoop(s, a);
        tick();
        checkOutput("wb_nop", 32'(wb_valid), 32'd0);
        snoop_inv = 1'b0;
    endtask

    initial begin
        nRST       = 1'b0;
        ex_valid   = 1'b0;
        ex_memctrl = '0;
        ex_wbctrl  = '0;
        ex_atomic  = 1'b0;
        ex_aluout  = '0;
        ex_store   = '0;
        ex_rd      = '0;
        dhit       = 1'b0;
        dload      = '0;
        snoop_inv  = 1'b0;
        snoop_addr = '0;
        modelLinkValid = 1'b0;
        modelLinkAddr  = '0;
        tick();
        tick();
        checkOutput("rst_req", {30'd0, dREN, dWEN}, 32'd0);
        checkOutput("rst_daddr", daddr, 32'd0);
        checkOutput("rst_dstore", dstore, 32'd0);
        checkOutput("rst_stall", 32'(stall_mem), 32'd0);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_wb_wdat", wb_wdat, 32'd0);
        checkOutput("rst_wb_halt", 32'(wb_halt), 32'd0);
        checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
        checkOutput("rst_wb_wbctrl", 32'(wb_wbctrl), 32'd0);
        nRST = 1'b1;

        $display("[TB] directed scenarios");
        applyStimulus(K_ALU, 32'h1234, 32'h0, 32'h0, 5'd5, 4'h3, 0, 1'b0, 32'h0, 0);
        applyStimulus(K_LW, 32'h100, 32'h0, 32'hDEADBEEF, 5'd7, 4'h1, 3, 1'b0, 32'h0, 0);
        applyStimulus(K_LL, 32'h200, 32'h0, 32'hCAFE0001, 5'd8, 4'h2, 1, 1'b0, 32'h0, 0);
        applyStimulus(K_SC, 32'h200, 32'h7, 32'h0, 5'd9, 4'h4, 2, 1'b0, 32'h0, 0);
        applyStimulus(K_SC, 32'h200, 32'h8, 32'h0, 5'd9, 4'h4, 0, 1'b0, 32'h0, 0);
        applyStimulus(K_LL, 32'h200, 32'h0, 32'h11, 5'd8, 4'h2, 0, 1'b0, 32'h0, 0);
        applyStimulus(K_SC, 32'h200, 32'h7, 32'h0, 5'd9, 4'h4, 0, 1'b1, 32'h202, 0);
        applyStimulus(K_LL, 32'h400, 32'h0, 32'h22, 5'd3, 4'h6, 0, 1'b0, 32'h400, 2);
        applyStimulus(K_SC, 32'h400, 32'h5, 32'h0, 5'd4, 4'h6, 1, 1'b0, 32'h0, 0);
        applyStimulus(K_LL, 32'h500, 32'h0, 32'h33, 5'd3, 4'h0, 0, 1'b0, 32'h0, 0);
        applyStimulus(K_SW, 32'h504, 32'hAA, 32'h0, 5'd0, 4'h0, 1, 1'b0, 32'h0, 0);
        applyStimulus(K_SC, 32'h500, 32'h5, 32'h0, 5'd4, 4'h6, 0, 1'b0, 32'h0, 0);
        applyStimulus(K_LL, 32'h500, 32'h0, 32'h44, 5'd3, 4'h0, 0, 1'b0, 32'h0, 0);
        applyStimulus(K_RW, 32'h502, 32'hBB, 32'h0, 5'd0, 4'h0, 1, 1'b0, 32'h0, 0);
        applyStimulus(K_SC, 32'h500, 32'h5, 32'h0, 5'd4, 4'h6, 0, 1'b0, 32'h0, 0);
        applyStimulus(K_HALT, 32'h0, 32'h0, 32'h0, 5'd0, 4'hF, 0, 1'b0, 32'h0, 0);

        $display("[TB] reset during an outstanding store");
        applyStimulus(K_LL, 32'h300, 32'h0, 32'h55, 5'd2, 4'h1, 0, 1'b0, 32'h0, 0);
        ex_valid   = 1'b1;
        ex_memctrl = 5'b00010;
        ex_atomic  = 1'b0;
        ex_aluout  = 32'h300;
        ex_store   = 32'h66;
        #1;
        checkOutput("sw_stall", 32'(stall_mem), 32'd1);
        tick();
        #1;
        checkOutput("sw_dWEN", 32'(dWEN), 32'd1);
        checkOutput("sw_daddr", daddr, 32'h300);
        nRST     = 1'b0;
        ex_valid = 1'b0;
        tick();
        checkOutput("abort_dWEN", 32'(dWEN), 32'd0);
        checkOutput("abort_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("abort_stall", 32'(stall_mem), 32'd0);
        modelLinkValid = 1'b0;
        nRST = 1'b1;
        applyStimulus(K_SC, 32'h300, 32'h9, 32'h0, 5'd1, 4'h2, 0, 1'b0, 32'h0, 0);
        idleCycle(1'b0, 32'h0);

        $display("[TB] random instruction stream");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                idleCycle($urandom_range(0, 1) == 1, pickAddr());
            applyStimulus(int'($urandom_range(0, 6)), pickAddr(), $urandom, $urandom,
                          5'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                          $urandom_range(0, 3) == 0, pickAddr(), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
